// File: rtl/wifire_tx.sv
// wifire_tx: IEEE 802.15.4 transmit framer.
// Host software loads an MPDU into a 32-bit frame buffer, sets the PSDU length
// and starts the frame over the settings bus. The block then streams 4-bit
// symbols to the O-QPSK modulator in this order: preamble, SFD, length byte,
// MPDU, and a CRC-16/KERMIT FCS. Every byte is sent low nibble first.
// irq_done_o is a level interrupt raised when a frame completes.
module wifire_tx #(
    parameter int BASE     = 16,
    parameter int BUF_AW   = 5,
    parameter int PRE_SYMS = 8
) (
    input  logic              dsp_clk,
    input  logic              reset,
    input  logic              set_stb,
    input  logic [7:0]        set_addr,
    input  logic [31:0]       set_data,
    input  logic              buf_we_i,
    input  logic [BUF_AW-1:0] buf_adr_i,
    input  logic [31:0]       buf_dat_i,
    output logic [3:0]        tx_sym_o,
    output logic              tx_sym_stb_o,
    input  logic              tx_sym_rdy_i,
    output logic              tx_busy_o,
    output logic              irq_done_o
);

    localparam logic [7:0]        ADDR_START = 8'(BASE);
    localparam logic [7:0]        ADDR_LEN   = 8'(BASE + 1);
    localparam logic [7:0]        ADDR_CLR   = 8'(BASE + 2);
    localparam logic [7:0]        ADDR_ABORT = 8'(BASE + 3);
    localparam logic [6:0]        PRE_LAST   = 7'(PRE_SYMS - 1);
    localparam logic [BUF_AW+1:0] IDX_ONE    = (BUF_AW + 2)'(1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_PRE, ST_SFD, ST_LEN, ST_PSDU, ST_FCS, ST_DONE
    } state_t;

    // One reflected CRC-16 (poly 0x8408) step over a whole byte.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    state_t            state_q, state_d;
    logic [6:0]        cnt_q, cnt_d;          // preamble count / PSDU bytes left / FCS byte select
    logic              lo_q, lo_d;            // current symbol is the low nibble of cur_byte
    logic [7:0]        cur_byte_q, cur_byte_d;
    logic [BUF_AW+1:0] fetch_idx_q, fetch_idx_d;  // next MPDU byte to load
    logic [15:0]       crc_q, crc_d;
    logic [6:0]        len_q, len_d;          // host-visible length register
    logic [6:0]        frame_len_q, frame_len_d;  // length latched at start
    logic [3:0]        sym_q, sym_d;
    logic              stb_q, stb_d;
    logic              busy_q, busy_d;
    logic              irq_q, irq_d;

    logic [31:0] buf_mem [2**BUF_AW];
    logic [31:0] rd_word_q;
    logic [7:0]  rd_byte;
    logic [7:0]  next_byte;
    logic        load_byte;

    logic start_wr, len_wr, clr_wr, abort_wr, xfer;
    logic unused_data;

    assign start_wr    = set_stb && (set_addr == ADDR_START);
    assign len_wr      = set_stb && (set_addr == ADDR_LEN);
    assign clr_wr      = set_stb && (set_addr == ADDR_CLR);
    assign abort_wr    = set_stb && (set_addr == ADDR_ABORT);
    assign xfer        = stb_q && tx_sym_rdy_i;
    assign unused_data = ^set_data[31:7];

    // Frame buffer: host writes are dropped while a frame is in flight; the
    // word holding fetch_idx is read every cycle so the next byte is always ready.
    // NOTE: memory arrays carry no reset; their contents are defined only by writes.
    always_ff @(posedge dsp_clk) begin
        if (buf_we_i && !busy_q) begin
            buf_mem[buf_adr_i] <= buf_dat_i;
        end
        rd_word_q <= buf_mem[fetch_idx_q[BUF_AW+1:2]];
    end

    // Pick the byte lane of the prefetched word (little-endian packing).
    always_comb begin
        rd_byte = rd_word_q[7:0];
        case (fetch_idx_q[1:0])
            2'd1:    rd_byte = rd_word_q[15:8];
            2'd2:    rd_byte = rd_word_q[23:16];
            2'd3:    rd_byte = rd_word_q[31:24];
            default: rd_byte = rd_word_q[7:0];
        endcase
    end

    // Next-state logic: settings decode, symbol sequencing, CRC and interrupt.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        lo_d        = lo_q;
        cur_byte_d  = cur_byte_q;
        fetch_idx_d = fetch_idx_q;
        crc_d       = crc_q;
        len_d       = len_q;
        frame_len_d = frame_len_q;
        sym_d       = sym_q;
        stb_d       = stb_q;
        busy_d      = busy_q;
        irq_d       = irq_q;
        next_byte   = 8'h00;
        load_byte   = 1'b0;

        if (len_wr) len_d = set_data[6:0];
        if (clr_wr) irq_d = 1'b0;

        if (abort_wr && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            stb_d   = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_wr && len_q >= 7'd3) begin
                        state_d     = ST_PRE;
                        cnt_d       = 7'd0;
                        frame_len_d = len_q;
                        fetch_idx_d = '0;
                        crc_d       = 16'h0000;
                        irq_d       = 1'b0;
                        busy_d      = 1'b1;
                        stb_d       = 1'b1;
                        sym_d       = 4'h0;
                    end
                end
                ST_PRE: begin
                    if (xfer) begin
                        if (cnt_q == PRE_LAST) begin
                            state_d   = ST_SFD;
                            next_byte = 8'hA7;
                            load_byte = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 7'd1;
                        end
                    end
                end
                ST_SFD, ST_LEN, ST_PSDU, ST_FCS: begin
                    if (xfer && lo_q) begin
                        sym_d = cur_byte_q[7:4];
                        lo_d  = 1'b0;
                    end else if (xfer) begin
                        case (state_q)
                            ST_SFD: begin
                                state_d   = ST_LEN;
                                next_byte = {1'b0, frame_len_q};
                                load_byte = 1'b1;
                            end
                            ST_LEN: begin
                                state_d     = ST_PSDU;
                                next_byte   = rd_byte;
                                load_byte   = 1'b1;
                                crc_d       = crc16_byte(crc_q, rd_byte);
                                fetch_idx_d = fetch_idx_q + IDX_ONE;
                                cnt_d       = frame_len_q - 7'd3;
                            end
                            ST_PSDU: begin
                                if (cnt_q != 7'd0) begin
                                    next_byte   = rd_byte;
                                    load_byte   = 1'b1;
                                    crc_d       = crc16_byte(crc_q, rd_byte);
                                    fetch_idx_d = fetch_idx_q + IDX_ONE;
                                    cnt_d       = cnt_q - 7'd1;
                                end else begin
                                    state_d   = ST_FCS;
                                    next_byte = crc_q[7:0];
                                    load_byte = 1'b1;
                                    cnt_d     = 7'd0;
                                end
                            end
                            ST_FCS: begin
                                if (cnt_q == 7'd0) begin
                                    next_byte = crc_q[15:8];
                                    load_byte = 1'b1;
                                    cnt_d     = 7'd1;
                                end else begin
                                    state_d = ST_DONE;
                                    stb_d   = 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_DONE: begin
                    // Setting the interrupt here overrides a simultaneous clear write.
                    irq_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase

            if (load_byte) begin
                cur_byte_d = next_byte;
                sym_d      = next_byte[3:0];
                lo_d       = 1'b1;
            end
        end
    end

    // State and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge dsp_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 7'd0;
            lo_q        <= 1'b0;
            cur_byte_q  <= 8'h00;
            fetch_idx_q <= '0;
            crc_q       <= 16'h0000;
            len_q       <= 7'd0;
            frame_len_q <= 7'd0;
            sym_q       <= 4'h0;
            stb_q       <= 1'b0;
            busy_q      <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lo_q        <= lo_d;
            cur_byte_q  <= cur_byte_d;
            fetch_idx_q <= fetch_idx_d;
            crc_q       <= crc_d;
            len_q       <= len_d;
            frame_len_q <= frame_len_d;
            sym_q       <= sym_d;
            stb_q       <= stb_d;
            busy_q      <= busy_d;
            irq_q       <= irq_d;
        end
    end

    assign tx_sym_o     = sym_q;
    assign tx_sym_stb_o = stb_q;
    assign tx_busy_o    = busy_q;
    assign irq_done_o   = irq_q;

endmodule

// File: tb/tb_wifire_tx.sv
// Testbench for wifire_tx: table of frame scenarios plus randomized frames,
// checked against a frame-level reference model (byte list -> nibble list,
// bit-serial CRC-16/KERMIT), and hand-written abort / busy-write / irq sequences.
module tb_wifire_tx;

    localparam int BASE     = 16;
    localparam int BUF_AW   = 5;
    localparam int PRE_SYMS = 8;

    logic              dsp_clk = 1'b0;
    logic              reset   = 1'b0;
    logic              set_stb;
    logic [7:0]        set_addr;
    logic [31:0]       set_data;
    logic              buf_we_i;
    logic [BUF_AW-1:0] buf_adr_i;
    logic [31:0]       buf_dat_i;
    logic [3:0]        tx_sym_o;
    logic              tx_sym_stb_o;
    logic              tx_sym_rdy_i;
    logic              tx_busy_o;
    logic              irq_done_o;

    wifire_tx #(.BASE(BASE), .BUF_AW(BUF_AW), .PRE_SYMS(PRE_SYMS)) dut (
        .dsp_clk      (dsp_clk),
        .reset        (reset),
        .set_stb      (set_stb),
        .set_addr     (set_addr),
        .set_data     (set_data),
        .buf_we_i     (buf_we_i),
        .buf_adr_i    (buf_adr_i),
        .buf_dat_i    (buf_dat_i),
        .tx_sym_o     (tx_sym_o),
        .tx_sym_stb_o (tx_sym_stb_o),
        .tx_sym_rdy_i (tx_sym_rdy_i),
        .tx_busy_o    (tx_busy_o),
        .irq_done_o   (irq_done_o)
    );

    always #5 dsp_clk = ~dsp_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int         cyc = 0;
    logic [3:0] got_q[$];
    int         last_xfer_cyc = -1;
    int         irq_rise_cyc  = -1;
    bit         busy_seen     = 1'b0;
    bit         prev_stall    = 1'b0;
    logic [3:0] prev_sym      = 4'h0;
    logic       prev_irq      = 1'b0;

    always @(posedge dsp_clk) cyc++;

    always @(negedge dsp_clk) begin
        if (reset) begin
            if (prev_stall) begin
                check("hold_sym", 32'(tx_sym_o), 32'(prev_sym));
                check("hold_stb", 32'(tx_sym_stb_o), 32'd1);
            end
            if (tx_sym_stb_o && tx_sym_rdy_i) begin
                got_q.push_back(tx_sym_o);
                last_xfer_cyc = cyc;
            end
            if (tx_busy_o) busy_seen = 1'b1;
            if (irq_done_o && !prev_irq) irq_rise_cyc = cyc;
        end
        prev_stall = reset && tx_sym_stb_o && !tx_sym_rdy_i;
        prev_sym   = tx_sym_o;
        prev_irq   = irq_done_o;
    end

    // ---------------- ready driver ----------------
    int rdy_mode = 0;  // 0: always ready, 1: toggle, 2: random

    initial begin
        tx_sym_rdy_i = 1'b0;
        forever begin
            @(posedge dsp_clk);
            #1;
            case (rdy_mode)
                0:       tx_sym_rdy_i = 1'b1;
                1:       tx_sym_rdy_i = ~tx_sym_rdy_i;
                default: tx_sym_rdy_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] shadow [128];
    logic [3:0] exp_q[$];

    function automatic logic [15:0] crc_model(input int nbytes);
        logic [15:0] crc;
        logic        fb;
        crc = 16'h0000;
        for (int i = 0; i < nbytes; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb  = crc[0] ^ shadow[i][b];
                crc = crc >> 1;
                if (fb) crc = crc ^ 16'h8408;
            end
        end
        return crc;
    endfunction

    function automatic void push_byte(input logic [7:0] b);
        exp_q.push_back(b[3:0]);
        exp_q.push_back(b[7:4]);
    endfunction

    function automatic void build_expected(input int len);
        logic [15:0] fcs;
        exp_q.delete();
        for (int i = 0; i < PRE_SYMS; i++) exp_q.push_back(4'h0);
        push_byte(8'hA7);
        push_byte(8'(len));
        for (int i = 0; i < len - 2; i++) push_byte(shadow[i]);
        fcs = crc_model(len - 2);
        push_byte(fcs[7:0]);
        push_byte(fcs[15:8]);
    endfunction

    function automatic void fill_shadow(input bit ascii);
        for (int i = 0; i < 128; i++) begin
            if (ascii && i < 9) shadow[i] = 8'(8'h31 + i);
            else                shadow[i] = 8'($urandom_range(0, 255));
        end
    endfunction

    // ---------------- bus tasks ----------------
    task automatic set_write_now(input logic [7:0] a, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        @(posedge dsp_clk);
        #1;
        set_stb  = 1'b0;
    endtask

    task automatic set_write(input logic [7:0] a, input logic [31:0] d);
        @(posedge dsp_clk);
        #1;
        set_write_now(a, d);
    endtask

    task automatic buf_write(input int w, input logic [31:0] d);
        @(posedge dsp_clk);
        #1;
        buf_we_i  = 1'b1;
        buf_adr_i = BUF_AW'(w);
        buf_dat_i = d;
        @(posedge dsp_clk);
        #1;
        buf_we_i  = 1'b0;
    endtask

    task automatic load_buffer();
        for (int w = 0; w < 32; w++)
            buf_write(w, {shadow[4*w+3], shadow[4*w+2], shadow[4*w+1], shadow[4*w]});
    endtask

    task automatic start_frame(input string name, input int len, input bit expect_frame);
        set_write(8'(BASE + 1), 32'(len));
        got_q.delete();
        irq_rise_cyc  = -1;
        last_xfer_cyc = -1;
        busy_seen     = 1'b0;
        set_write(8'(BASE), 32'd0);
        check({name, ":busy_after_start"}, 32'(tx_busy_o), 32'(expect_frame));
        check({name, ":stb_after_start"}, 32'(tx_sym_stb_o), 32'(expect_frame));
    endtask

    task automatic finish_frame(input string name, input int len, input bit expect_frame);
        int waited;
        if (expect_frame) begin
            waited = 0;
            while (irq_rise_cyc < 0 && waited < 3000) begin
                @(negedge dsp_clk);
                waited++;
            end
            check({name, ":irq_seen"}, 32'(irq_rise_cyc >= 0), 32'd1);
            build_expected(len);
            check({name, ":nsyms"}, 32'(got_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
                check($sformatf("%s:sym%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
            check({name, ":irq_latency"}, 32'(irq_rise_cyc - last_xfer_cyc), 32'd2);
            check({name, ":busy_end"}, 32'(tx_busy_o), 32'd0);
            check({name, ":stb_end"}, 32'(tx_sym_stb_o), 32'd0);
            check({name, ":irq_end"}, 32'(irq_done_o), 32'd1);
        end else begin
            repeat (40) @(negedge dsp_clk);
            check({name, ":no_syms"}, 32'(got_q.size()), 32'd0);
            check({name, ":no_busy"}, 32'(busy_seen), 32'd0);
            check({name, ":no_irq"}, 32'(irq_rise_cyc < 0), 32'd1);
        end
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        string       name;
        int          len;
        bit          ascii;
        int          rdy;
        bit          expect_frame;
        bit          check_fcs;
        logic [15:0] exp_fcs;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [15:0] fcs_got;
        int          n;
        int          w;

        set_stb   = 1'b0;
        set_addr  = 8'h00;
        set_data  = 32'h0;
        buf_we_i  = 1'b0;
        buf_adr_i = '0;
        buf_dat_i = 32'h0;

        repeat (3) @(posedge dsp_clk);
        #1;
        check("reset:sym", 32'(tx_sym_o), 32'd0);
        check("reset:stb", 32'(tx_sym_stb_o), 32'd0);
        check("reset:busy", 32'(tx_busy_o), 32'd0);
        check("reset:irq", 32'(irq_done_o), 32'd0);
        reset = 1'b1;

        // A start before any length write sees length 0 and is ignored.
        got_q.delete();
        busy_seen    = 1'b0;
        irq_rise_cyc = -1;
        set_write(8'(BASE), 32'd0);
        finish_frame("start_len0", 0, 1'b0);

        vecs.push_back('{"kermit_rdy1",   11,  1'b1, 0, 1'b1, 1'b1, 16'h2189});
        vecs.push_back('{"kermit_toggle", 11,  1'b1, 1, 1'b1, 1'b1, 16'h2189});
        vecs.push_back('{"len2_ignored",  2,   1'b0, 0, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{"len5",          5,   1'b0, 0, 1'b1, 1'b0, 16'h0000});
        vecs.push_back('{"len3_min",      3,   1'b0, 2, 1'b1, 1'b0, 16'h0000});
        vecs.push_back('{"len127_max",    127, 1'b0, 0, 1'b1, 1'b0, 16'h0000});
        vecs.push_back('{"len127_rand",   127, 1'b0, 2, 1'b1, 1'b0, 16'h0000});

        foreach (vecs[k]) begin
            rdy_mode = vecs[k].rdy;
            fill_shadow(vecs[k].ascii);
            load_buffer();
            start_frame(vecs[k].name, vecs[k].len, vecs[k].expect_frame);
            finish_frame(vecs[k].name, vecs[k].len, vecs[k].expect_frame);
            if (vecs[k].check_fcs) begin
                n = got_q.size();
                fcs_got = 16'h0;
                if (n >= 4) fcs_got = {got_q[n-1], got_q[n-2], got_q[n-3], got_q[n-4]};
                check({vecs[k].name, ":fcs"}, 32'(fcs_got), 32'(vecs[k].exp_fcs));
            end
        end

        // Abort after the 12th transfer, then a clean frame.
        rdy_mode = 0;
        fill_shadow(1'b1);
        load_buffer();
        start_frame("abort", 11, 1'b1);
        w = 0;
        while (got_q.size() < 12 && w < 200) begin
            @(posedge dsp_clk);
            #1;
            w++;
        end
        check("abort:reached12", 32'(got_q.size() >= 12), 32'd1);
        set_write_now(8'(BASE + 3), 32'd0);
        check("abort:stb", 32'(tx_sym_stb_o), 32'd0);
        check("abort:busy", 32'(tx_busy_o), 32'd0);
        n = got_q.size();
        repeat (5) @(negedge dsp_clk);
        check("abort:no_more_syms", 32'(got_q.size()), 32'(n));
        check("abort:irq_low", 32'(irq_done_o), 32'd0);
        check("abort:no_irq_rise", 32'(irq_rise_cyc < 0), 32'd1);
        start_frame("after_abort", 11, 1'b1);
        finish_frame("after_abort", 11, 1'b1);

        // Buffer writes, a length write and a second start during a frame.
        fill_shadow(1'b0);
        load_buffer();
        start_frame("busy_wr", 20, 1'b1);
        repeat (4) @(posedge dsp_clk);
        buf_write(0, 32'hDEADBEEF);
        buf_write(3, 32'h12345678);
        set_write(8'(BASE + 1), 32'd5);
        set_write(8'(BASE), 32'd0);
        finish_frame("busy_wr", 20, 1'b1);

        // Clear write landing in the DONE cycle loses to the set.
        fill_shadow(1'b1);
        load_buffer();
        start_frame("irq_clr", 11, 1'b1);
        build_expected(11);
        w = 0;
        while (got_q.size() < exp_q.size() && w < 500) begin
            @(posedge dsp_clk);
            #1;
            w++;
        end
        check("irq_clr:all_sent", 32'(got_q.size()), 32'(exp_q.size()));
        set_write_now(8'(BASE + 2), 32'd0);
        check("irq_clr:set_wins", 32'(irq_done_o), 32'd1);
        check("irq_clr:busy", 32'(tx_busy_o), 32'd0);
        set_write(8'(BASE + 2), 32'd0);
        check("irq_clr:cleared", 32'(irq_done_o), 32'd0);

        // Randomized frames.
        for (int r = 0; r < 6; r++) begin
            int len;
            rdy_mode = (r % 2 == 0) ? 2 : 0;
            len = $urandom_range(3, 127);
            fill_shadow(1'b0);
            load_buffer();
            start_frame($sformatf("rand%0d", r), len, 1'b1);
            finish_frame($sformatf("rand%0d", r), len, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wifire_tx.md
Name: wifire_tx

Overview:
- IEEE 802.15.4 transmit framer: the transmit-side counterpart of the wifire receive path.
- Host software loads an MPDU (FCS excluded) into a local buffer, sets the PSDU length and starts the frame through the settings bus.
- The block then emits a 4-bit symbol stream to the O-QPSK modulator: preamble, SFD, length byte, MPDU and computed CRC-16 FCS.
- It raises an interrupt when the frame is done.

Parameters:
BASE, 16, first settings-bus address owned by the block
BUF_AW, 5, word-address width of the 32-bit frame buffer (32 words = 128 bytes)
PRE_SYMS, 8, number of zero preamble symbols

Ports:
dsp_clk  in  1  block clock
reset  in  1  asynchronous, active-low reset
set_stb  in  1  settings-bus write strobe
set_addr  in  8  settings-bus address
set_data  in  32  settings-bus data
buf_we_i  in  1  frame-buffer write enable
buf_adr_i  in  BUF_AW  frame-buffer word address
buf_dat_i  in  32  frame-buffer write data
tx_sym_o  out  4  symbol to the modulator
tx_sym_stb_o  out  1  tx_sym_o is valid
tx_sym_rdy_i  in  1  modulator accepts the symbol
tx_busy_o  out  1  frame in progress
irq_done_o  out  1  frame-complete interrupt (level)

Behaviour:
- Reset values: all outputs 0; state IDLE; length register 0; CRC register 0.
- Settings writes:
  - BASE+0: start.
  - BASE+1: length, taken from set_data[6:0] (PSDU length including the 2 FCS bytes).
  - BASE+2: clear irq_done_o.
  - BASE+3: abort.
  - Other addresses are ignored.
- Buffer layout: MPDU byte i is in word i>>2, lane i[1:0]; lane 0 = bits [7:0]. This is the same little-endian packing the receiver uses.
- Buffer writes while tx_busy_o=1 are dropped. Buffer reads are synchronous with 1-cycle latency.
- Start handling:
  - Accepted only in IDLE with length >= 3.
  - Otherwise ignored; no state change and no irq.
  - An accepted start clears irq_done_o, zeroes the CRC, and sets tx_busy_o on the next cycle.
- Symbol handshake:
  - A symbol is transferred on any cycle with tx_sym_stb_o && tx_sym_rdy_i.
  - While stb=1 and rdy=0, tx_sym_o holds stable.
  - With rdy held high, one symbol is transferred per cycle with no bubbles. MPDU bytes are prefetched so this holds.
- Nibble order: every byte is sent low nibble first.
- State machine (stb goes high the cycle after start is accepted):
  - PRE: PRE_SYMS symbols of 0x0.
  - SFD: byte 0xA7, sent as 7 then A.
  - LEN: byte {1'b0, length}.
  - PSDU: length-2 buffer bytes, starting at byte 0.
  - FCS: CRC low byte, then high byte.
  - DONE: 1 cycle, then return to IDLE.
- CRC: CRC-16/KERMIT.
  - Poly x^16+x^12+x^5+1, reflected (0x8408), init 0x0000, no final xor.
  - Updated over PSDU bytes only, one byte per fetch.
- End of frame:
  - When the final FCS symbol transfers, tx_sym_stb_o drops the next cycle and the FSM enters DONE.
  - In DONE, irq_done_o is set and tx_busy_o is cleared.
  - irq_done_o stays high until a BASE+2 write or the next accepted start.
  - A clear write in the same cycle as DONE: the set wins.
- Abort: in any non-IDLE state, go to IDLE next cycle with stb=0 and busy=0. No irq is raised and irq_done_o keeps its value. Abort in IDLE is a no-op.
- Other writes while busy:
  - A length write while busy updates the register but does not affect the current frame; length is latched at start.
  - A start write while busy is ignored.
- Reset asserted mid-frame: immediate return to reset values; buffer contents are not guaranteed.
- Length 127: buffer bytes 0..124 are sent; the byte address must not wrap.

Test Plan:
- Reset, then load "123456789" (0x31..0x39) at bytes 0..8, length=11, start, rdy=1 -> 34 consecutive symbols: 0 x8, 7, A, B, 0, 1,3, 2,3, ..., 9,3, then 9, 8, 1, 2 (FCS 0x2189). irq_done_o rises 2 cycles after the last transfer.
- Same frame with rdy toggled 1-0-1-0 -> identical symbol sequence; tx_sym_o stable during every rdy=0 cycle; no duplicated or skipped symbols.
- length=2, start -> tx_busy_o stays 0, no stb, no irq; then length=5 with a valid start -> frame sent.
- Abort after the 12th transfer -> stb=0 and busy=0 next cycle, no irq; a new start then sends a complete, correct frame.
- Buffer write and second start during a frame -> both ignored; transmitted bytes and FCS match the pre-start buffer contents.
- irq clear write in the same cycle as DONE -> irq_done_o = 1; a later clear write -> irq_done_o = 0.
